// File: rtl/memory_access_stage.sv
// RV32I memory-access pipeline stage: registers the execute bundle, runs one
// request/response data-memory transaction per load/store, and extends load data.
module memory_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        e_to_m_valid,
  output logic        m_allow_in,
  input  logic        w_allow_in,
  output logic        m_to_w_valid,
  output logic        m_valid,
  input  logic [6:0]  E_opcode,
  input  logic [4:0]  E_rd,
  input  logic [2:0]  E_funct3,
  input  logic [31:0] E_valE,
  input  logic [31:0] E_valB,
  input  logic [31:0] E_default_pc,
  input  logic [31:0] E_cur_pc,
  input  logic [31:0] E_instr,
  input  logic [31:0] E_pred_pc,
  input  logic [31:0] E_predicted_pc,
  input  logic        E_commit,
  output logic [6:0]  M_opcode,
  output logic [4:0]  M_rd,
  output logic [31:0] M_valE,
  output logic [31:0] M_default_pc,
  output logic [31:0] M_cur_pc,
  output logic [31:0] M_instr,
  output logic [31:0] M_pred_pc,
  output logic [31:0] M_predicted_pc,
  output logic        M_commit,
  output logic [31:0] m_valM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

  state_e      state_q, state_d;
  logic        m_valid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [6:0]  opcode_q;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic [31:0] valE_q, valB_q, default_pc_q;
  logic [31:0] cur_pc_q, instr_q, pred_pc_q, predicted_pc_q;
  logic        commit_q;

  logic is_load, is_store, is_mem, m_ready_go, accept;

  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] w);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = w >> {off, 3'b000};
    b       = shifted[7:0];
    h       = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                            input logic [1:0] off);
    case (f3)
      3'b000:  return 4'b0001 << off;
      3'b001:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0]  f3,
                                             input logic [31:0] d);
    case (f3)
      3'b000:  return {4{d[7:0]}};
      3'b001:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  assign is_load    = (opcode_q == OP_LOAD);
  assign is_store   = (opcode_q == OP_STORE);
  assign is_mem     = is_load | is_store;
  assign m_ready_go = ~is_mem | (state_q == DONE);
  assign m_allow_in = ~m_valid_q | (m_ready_go & w_allow_in);
  assign m_to_w_valid = m_valid_q & m_ready_go;
  assign accept     = m_allow_in & e_to_m_valid;

  // Exactly one request cycle per access: IDLE issues and leaves on the same edge.
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (m_valid_q && is_mem) state_d = WAIT;
      WAIT: begin
        if (dmem_rvalid) begin
          state_d = DONE;
          if (is_load) rdata_d = dmem_rdata;
        end
      end
      DONE: if (w_allow_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      m_valid_q      <= 1'b0;
      rdata_q        <= '0;
      opcode_q       <= '0;
      rd_q           <= '0;
      funct3_q       <= '0;
      valE_q         <= '0;
      valB_q         <= '0;
      default_pc_q   <= '0;
      cur_pc_q       <= '0;
      instr_q        <= '0;
      pred_pc_q      <= '0;
      predicted_pc_q <= '0;
      commit_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (m_allow_in) m_valid_q <= e_to_m_valid;
      if (accept) begin
        opcode_q       <= E_opcode;
        rd_q           <= E_rd;
        funct3_q       <= E_funct3;
        valE_q         <= E_valE;
        valB_q         <= E_valB;
        default_pc_q   <= E_default_pc;
        cur_pc_q       <= E_cur_pc;
        instr_q        <= E_instr;
        pred_pc_q      <= E_pred_pc;
        predicted_pc_q <= E_predicted_pc;
        commit_q       <= E_commit;
      end
    end
  end

  assign m_valid        = m_valid_q;
  assign M_opcode       = opcode_q;
  assign M_rd           = rd_q;
  assign M_valE         = valE_q;
  assign M_default_pc   = default_pc_q;
  assign M_cur_pc       = cur_pc_q;
  assign M_instr        = instr_q;
  assign M_pred_pc      = pred_pc_q;
  assign M_predicted_pc = predicted_pc_q;
  assign M_commit       = commit_q;

  assign m_valM     = is_load ? load_extend(funct3_q, valE_q[1:0], rdata_q) : 32'd0;
  assign dmem_req   = (state_q == IDLE) & m_valid_q & is_mem;
  assign dmem_we    = m_valid_q & is_store;
  assign dmem_addr  = {valE_q[31:2], 2'b00};
  assign dmem_wstrb = dmem_we ? store_strb(funct3_q, valE_q[1:0]) : 4'b0000;
  assign dmem_wdata = dmem_we ? store_data(funct3_q, valB_q) : 32'd0;

endmodule
